debug_poke: RTL

- Debugger write-side companion to the seven-segment peek logic. The user loads a register or memory word from the board switches and a push button while the processor is halted.
- Target is chosen by switches[9]: 0 = register file, 1 = data memory. The address comes from the switches. Data is entered as 8 hex nibbles, MSB first.
- A single write is then issued to the processor through a strobe/acknowledge handshake.
- Sits beside the display block; its preview output feeds the display mux so the word being entered can be shown.

---
 rtl/debug_poke.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/debug_poke.sv
// Debugger write path: select a register/memory target from the switches, shift in
// eight hex nibbles on debounced key presses, then issue one strobe/ack write.
module debug_poke #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned ACK_TIMEOUT     = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [9:0]  switches,
  input  logic        keyN,
  input  logic        halted,
  input  logic        wrAck,
  output logic        regWrEn,
  output logic [4:0]  regWrAddr,
  output logic        memWrEn,
  output logic [31:0] memWrAddr,
  output logic [31:0] wrData,
  output logic [31:0] preview,
  output logic [3:0]  nibbleCount,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned ACW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic           sync1_q, sync2_q, deb_q, deb_d, press_q;
  logic [DCW-1:0] dcnt_q, dcnt_d;

  logic [1:0]     state_q, state_d;
  logic           tgt_q, tgt_d;
  logic           err_q, err_d;
  logic [4:0]     raddr_q, raddr_d;
  logic [31:0]    maddr_q, maddr_d;
  logic [31:0]    data_q, data_d;
  logic [3:0]     nib_q, nib_d;
  logic [ACW-1:0] to_q, to_d;

  // Debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync2_q != deb_q) begin
      if (dcnt_q == DCW'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q;
      else                                     dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      dcnt_q  <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= keyN;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      press_q <= deb_q & ~deb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    raddr_d = raddr_q;
    maddr_d = maddr_q;
    data_d  = data_q;
    nib_d   = nib_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (press_q && halted) begin
          if (!switches[9] && switches[4:0] == 5'd0) begin
            err_d = 1'b1;
          end else begin
            err_d  = 1'b0;
            tgt_d  = switches[9];
            if (switches[9]) maddr_d = {23'b0, switches[8:0]};
            else             raddr_d = switches[4:0];
            data_d  = '0;
            nib_d   = '0;
            state_d = S_ENTRY;
          end
        end
      end
      S_ENTRY: begin
        // Losing halt takes priority over a simultaneous press.
        if (!halted) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (press_q) begin
          data_d = {data_q[27:0], switches[3:0]};
          nib_d  = nib_q + 4'd1;
          if (nib_q == 4'd7) begin
            to_d    = '0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (wrAck) begin
          state_d = S_DONE;
        end else if (to_q == ACW'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      tgt_q   <= 1'b0;
      err_q   <= 1'b0;
      raddr_q <= '0;
      maddr_q <= '0;
      data_q  <= '0;
      nib_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      raddr_q <= raddr_d;
      maddr_q <= maddr_d;
      data_q  <= data_d;
      nib_q   <= nib_d;
      to_q    <= to_d;
    end
  end

  assign regWrEn     = (state_q == S_WRITE) && !tgt_q;
  assign memWrEn     = (state_q == S_WRITE) && tgt_q;
  assign regWrAddr   = raddr_q;
  assign memWrAddr   = maddr_q;
  assign wrData      = data_q;
  assign preview     = data_q;
  assign nibbleCount = nib_q;
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;

endmodule
